vita_ctx_arbiter: RTL and testbench

VITA_CTX_ARBITER -- requirements
Module: vita_ctx_arbiter

---
 rtl/vita_ctx_arbiter.sv | 132 +++++++++++++
 tb/tb_vita_ctx_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vita_ctx_arbiter.sv
// vita_ctx_arbiter: four-input fifo36 packet arbiter with a setting-bus port-enable register.
//
// Ports whose src_rdy_i is high and whose enable bit is set compete in IDLE; the winner is
// the first candidate at or above the round-robin pointer. Its packet is then passed through
// combinationally until the EOF line (data bit 33) transfers. The pointer then moves one past
// the winner.
//
// Build option: define VITA_CTX_ARB_PRIO0_EN to let port 0 win every arbitration in which it
// is a candidate. The remaining ports stay round-robin.
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous active-high reset (enable register returns to 4'b1111)
//   clear      synchronous soft clear (enable register untouched)
//   set_stb    setting-bus strobe; set_addr/set_data address and payload
//   data_i     4 x 36-bit input streams, port n at [36n+35:36n]
//   src_rdy_i  per-port source ready;    dst_rdy_o per-port destination ready
//   data_o     merged 36-bit stream (bit 32 SOF, bit 33 EOF)
//   src_rdy_o  merged source ready;      dst_rdy_i merged destination ready
//   debug      {24'd0, enable[3:0], state, busy, grant[1:0]}
module vita_ctx_arbiter #(
  parameter logic [7:0] BASE = 8'd0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           set_stb,
  input  logic [7:0]     set_addr,
  input  logic [31:0]    set_data,
  input  logic [143:0]   data_i,
  input  logic [3:0]     src_rdy_i,
  output logic [3:0]     dst_rdy_o,
  output logic [35:0]    data_o,
  output logic           src_rdy_o,
  input  logic           dst_rdy_i,
  output logic [31:0]    debug
);

  typedef enum logic {StIdle = 1'b0, StPass = 1'b1} state_e;

  state_e      state_q;
  logic [1:0]  grant_q;
  logic [1:0]  ptr_q;
  logic [3:0]  enable_q;

  logic [35:0] port_data [4];
  logic [3:0]  cand;
  logic [1:0]  winner;
  logic        has_winner;
  logic        xfer;
  logic        xfer_eof;

  logic        unused_set_data;
  assign unused_set_data = ^set_data[31:4];

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      port_data[n] = data_i[36*n +: 36];
    end
  end

  // Scan from the highest offset down so the candidate nearest to ptr_q is the last to match.
  always_comb begin
    cand       = src_rdy_i & enable_q;
    winner     = ptr_q;
    has_winner = |cand;
    for (int i = 3; i >= 0; i--) begin
      if (cand[ptr_q + 2'(i)]) begin
        winner = ptr_q + 2'(i);
      end
    end
`ifdef VITA_CTX_ARB_PRIO0_EN
    if (cand[0]) begin
      winner = 2'd0;
    end
`endif
  end

  // Pass-through adds no latency: outputs follow the locked grant combinationally.
  always_comb begin
    data_o    = '0;
    src_rdy_o = 1'b0;
    dst_rdy_o = '0;
    if (state_q == StPass) begin
      data_o             = port_data[grant_q];
      src_rdy_o          = src_rdy_i[grant_q];
      dst_rdy_o[grant_q] = dst_rdy_i;
    end
  end

  assign xfer     = src_rdy_o & dst_rdy_i;
  assign xfer_eof = xfer & data_o[33];

  assign debug = {24'd0, enable_q, state_q, xfer, grant_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= 2'd0;
      ptr_q    <= 2'd0;
      enable_q <= 4'b1111;
    end else begin
      // A write coinciding with clear still lands; clear leaves the enable register alone.
      if (set_stb && (set_addr == BASE)) begin
        enable_q <= set_data[3:0];
      end
      if (clear) begin
        state_q <= StIdle;
        grant_q <= 2'd0;
        ptr_q   <= 2'd0;
      end else begin
        case (state_q)
          StIdle: begin
            if (has_winner) begin
              grant_q <= winner;
              state_q <= StPass;
            end
          end
          StPass: begin
            // Grant is held regardless of src_rdy or enable until the EOF line moves.
            if (xfer_eof) begin
              state_q <= StIdle;
              ptr_q   <= grant_q + 2'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vita_ctx_arbiter.sv
// Testbench for vita_ctx_arbiter: per-port source models feed packets, expected lines are
// queued in the hand-derived output order, and a negedge monitor checks every transfer.
module tb_vita_ctx_arbiter;

  localparam logic [7:0] Base = 8'h10;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           clear = 1'b0;
  logic           set_stb = 1'b0;
  logic [7:0]     set_addr = '0;
  logic [31:0]    set_data = '0;
  logic [143:0]   data_i;
  logic [3:0]     src_rdy_i;
  logic [3:0]     dst_rdy_o;
  logic [35:0]    data_o;
  logic           src_rdy_o;
  logic           dst_rdy_i = 1'b1;
  logic [31:0]    debug;

  vita_ctx_arbiter #(.BASE(Base)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .set_stb   (set_stb),
    .set_addr  (set_addr),
    .set_data  (set_data),
    .data_i    (data_i),
    .src_rdy_i (src_rdy_i),
    .dst_rdy_o (dst_rdy_o),
    .data_o    (data_o),
    .src_rdy_o (src_rdy_o),
    .dst_rdy_i (dst_rdy_i),
    .debug     (debug)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  logic watch13 = 1'b0;

  typedef struct packed {
    logic [1:0]  port;
    logic [35:0] data;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;

  // Source models: each port streams its loaded lines; a gap flag idles src_rdy one cycle.
  logic [35:0] src_mem [4][32];
  logic        gap_mem [4][32];
  int          src_len [4] = '{default: 0};
  int          src_rd  [4] = '{default: 0};
  logic [3:0]  gap_done = '0;

  always_comb begin
    data_i    = '0;
    src_rdy_i = '0;
    for (int n = 0; n < 4; n++) begin
      if (src_rd[n] < src_len[n]) begin
        data_i[36*n +: 36] = src_mem[n][src_rd[n][4:0]];
        src_rdy_i[n]       = !(gap_mem[n][src_rd[n][4:0]] && !gap_done[n]);
      end
    end
  end

  always @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (src_rd[n] < src_len[n]) begin
        if (src_rdy_i[n] && dst_rdy_o[n]) begin
          src_rd[n]   <= src_rd[n] + 1;
          gap_done[n] <= 1'b0;
        end else if (gap_mem[n][src_rd[n][4:0]] && !gap_done[n]) begin
          gap_done[n] <= 1'b1;
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] word(input int p, input int k, input int l, input int n);
    logic sof;
    logic eof;
    sof = (l == 0);
    eof = (l == n - 1);
    return {2'b00, eof, sof, 8'hA5, 8'(p), 8'(k), 8'(l)};
  endfunction

  task automatic load_pkt(input int p, input int k, input int n, input logic [7:0] gaps);
    for (int l = 0; l < n; l++) begin
      src_mem[p][src_len[p] + l] = word(p, k, l, n);
      gap_mem[p][src_len[p] + l] = gaps[l];
    end
    src_len[p] = src_len[p] + n;
  endtask

  task automatic expect_pkt(input int p, input int k, input int n);
    exp_t e;
    for (int l = 0; l < n; l++) begin
      e.port = 2'(p);
      e.data = word(p, k, l, n);
      sb.push_back(e);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    @(posedge clk);
    #1 set_stb = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    cmp(name, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compare each transfer against the queue head; a stalled line must hold steady.
  always @(negedge clk) begin
    if (!reset) begin
      if (watch13) cmp("dst_rdy_1_3_off", 64'(dst_rdy_o & 4'b1010), 64'd0);
      if (src_rdy_o && dst_rdy_i) begin
        xfers++;
        if (sb.size() == 0) begin
          cmp("unexpected_xfer", 64'(data_o), 64'h0);
        end else begin
          mon_e = sb.pop_front();
          cmp("xfer_data", 64'(data_o), 64'(mon_e.data));
          cmp("xfer_dst_rdy", 64'(dst_rdy_o), 64'(4'b0001 << mon_e.port));
        end
      end else if (src_rdy_o && sb.size() != 0) begin
        cmp("stall_hold", 64'(data_o), 64'(sb[0].data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int x0;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_debug", 64'(debug), 64'h0000_00F0);
    cmp("reset_outs", 64'({src_rdy_o, dst_rdy_o, data_o}), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Four 3-line packets, served 0,1,2,3 in 16 clocks.
    for (int p = 0; p < 4; p++) begin
      load_pkt(p, 1, 3, 8'h00);
      expect_pkt(p, 1, 3);
    end
    repeat (15) @(posedge clk);
    #1 cmp("rr_timing_15", 64'(sb.size()), 64'd1);
    @(posedge clk);
    #1 cmp("rr_timing_16", 64'(sb.size()), 64'd0);
    cmp("rr_idle_after", 64'(debug[3]), 64'd0);

    // Port 2 locked through src_rdy gaps and an enable clear; port 1 waits for the EOF.
    load_pkt(2, 2, 5, 8'b0000_1010);
    expect_pkt(2, 2, 5);
    @(posedge clk);
    #1 cmp("lock_grant2", 64'({debug[3], debug[1:0]}), 64'b110);
    load_pkt(1, 2, 3, 8'h00);
    expect_pkt(1, 2, 3);
    wr(Base, 32'h0000_000B);
    drain("lock_drain", 60);
    wr(Base, 32'h0000_000F);

    // Stalls from dst_rdy_i toggling; exactly four transfers, EOF on the last.
    x0 = xfers;
    load_pkt(0, 3, 4, 8'h00);
    expect_pkt(0, 3, 4);
    for (int c = 0; c < 40 && sb.size() != 0; c++) begin
      @(posedge clk);
      #1 dst_rdy_i = ~dst_rdy_i;
    end
    dst_rdy_i = 1'b1;
    cmp("stall_drained", 64'(sb.size()), 64'd0);
    cmp("stall_xfer_count", 64'(xfers - x0), 64'd4);

    // Clear during line 2 of a 4-line port-3 packet; the tail is re-arbitrated afterwards.
    load_pkt(3, 4, 4, 8'h00);
    expect_pkt(3, 4, 4);
    @(posedge clk);
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    cmp("clear_debug", 64'(debug), 64'h0000_00F0);
    cmp("clear_src_rdy", 64'(src_rdy_o), 64'd0);
    drain("clear_tail_drain", 30);

    // Clear coinciding with a write keeps the write; other addresses are ignored.
    clear    = 1'b1;
    set_stb  = 1'b1;
    set_addr = Base;
    set_data = 32'h0000_0005;
    @(posedge clk);
    #1 clear = 1'b0;
    set_stb = 1'b0;
    cmp("clear_plus_write", 64'(debug), 64'h0000_0050);
    wr(Base + 8'd1, 32'h0000_0000);
    cmp("other_addr_ignored", 64'(debug[7:4]), 64'h5);

    // Enable 0101 with all ports requesting: 0,2,0,2 only.
    for (int p = 0; p < 4; p++) begin
      load_pkt(p, 5, 2, 8'h00);
      load_pkt(p, 6, 2, 8'h00);
    end
    expect_pkt(0, 5, 2);
    expect_pkt(2, 5, 2);
    expect_pkt(0, 6, 2);
    expect_pkt(2, 6, 2);
    watch13 = 1'b1;
    drain("en0101_drain", 40);
    watch13 = 1'b0;

    // Enable 0000: ports 1 and 3 still requesting, nothing moves.
    wr(Base, 32'h0000_0000);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1 cmp("en0000_idle", 64'({debug[3], src_rdy_o, dst_rdy_o}), 64'd0);
    end

    // Enable 1010: pointer sits at 3 after port 2's last EOF, so 3,1,3,1.
    wr(Base, 32'h0000_000A);
    expect_pkt(3, 5, 2);
    expect_pkt(1, 5, 2);
    expect_pkt(3, 6, 2);
    expect_pkt(1, 6, 2);
    drain("en1010_drain", 40);
    wr(Base, 32'h0000_000F);

    // Ports 0 and 1 with one-line packets; pointer starts at 2.
    load_pkt(0, 7, 1, 8'h00);
    load_pkt(0, 8, 1, 8'h00);
    load_pkt(1, 7, 1, 8'h00);
    load_pkt(1, 8, 1, 8'h00);
`ifdef VITA_CTX_ARB_PRIO0_EN
    expect_pkt(0, 7, 1);
    expect_pkt(0, 8, 1);
    expect_pkt(1, 7, 1);
    expect_pkt(1, 8, 1);
`else
    expect_pkt(0, 7, 1);
    expect_pkt(1, 7, 1);
    expect_pkt(0, 8, 1);
    expect_pkt(1, 8, 1);
`endif
    repeat (7) @(posedge clk);
    #1 cmp("oneline_timing_7", 64'(sb.size()), 64'd1);
    @(posedge clk);
    #1 cmp("oneline_timing_8", 64'(sb.size()), 64'd0);

    // Reset beats a coincident write.
    wr(Base, 32'h0000_0003);
    cmp("en_write_3", 64'(debug[7:4]), 64'h3);
    reset    = 1'b1;
    set_stb  = 1'b1;
    set_addr = Base;
    set_data = 32'h0000_0000;
    @(posedge clk);
    #1 set_stb = 1'b0;
    cmp("reset_beats_write", 64'(debug), 64'h0000_00F0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
